// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch front end with req/ack memory port and a PC-tagged FIFO to decode
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   RESET_PC  value of imem_addr while in reset
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   pc_in / pc_stall  current PC in; hold request to the PC register (0 = PC may advance)
//   flush             redirect: drops buffered entries and any in-flight response
//   imem_req/addr     registered read request; addr stable while req is high
//   imem_ack/rdata    memory response, data valid with ack
//   id_valid/instr/pc FIFO head to decode, accepted when id_ready is high
// Build option
//   FETCH_BYPASS_EN   forwards a response straight to decode when the FIFO is empty
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [31:0]     r_instr [DEPTH];
  logic [31:0]     r_pc    [DEPTH];
  logic            r_req;
  logic [31:0]     r_addr;
  logic            w_keep, w_issue, w_byp, w_fifo_valid, w_push, w_pop;

  assign imem_req  = r_req;
  assign imem_addr = r_addr;

  always_comb begin
    w_fifo_valid = r_count != '0;
    w_keep       = (r_state == WAIT) & imem_ack & ~flush;
    // a new fetch alongside an ack must leave room for the word being pushed now
    w_issue      = ~flush & (((r_state == IDLE) & (r_count < CW'(DEPTH))) |
                             (w_keep & (r_count < CW'(DEPTH - 1))));
`ifdef FETCH_BYPASS_EN
    w_byp        = w_keep & ~w_fifo_valid;
`else
    w_byp        = 1'b0;
`endif
    id_valid     = w_fifo_valid | w_byp;
    id_instr     = w_byp ? imem_rdata : r_instr[r_rptr];
    id_pc        = w_byp ? r_addr : r_pc[r_rptr];
    w_pop        = w_fifo_valid & id_ready & ~flush;
    w_push       = w_keep & ~(w_byp & id_ready);
    pc_stall     = ~(w_issue | flush);
    // flush without ack in WAIT leaves the request open but marks its data for discard
    w_next       = w_issue                                   ? WAIT  :
                   ((r_state == WAIT) & flush & ~imem_ack)   ? DRAIN :
                   ((r_state == IDLE) | imem_ack)            ? IDLE  : r_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= w_next != IDLE;
      if (w_issue) r_addr <= pc_in;
      if (flush) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop) r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= imem_rdata;
      r_pc[r_wptr]    <= r_addr;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: cycle table plus scoreboarded sequences for if_fetch_queue
module tb_if_fetch_queue;
  localparam logic [31:0] RPC = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst, flush, id_ready, imem_ack, pc_stall, imem_req, id_valid;
  logic [31:0] pc_in, imem_addr, imem_rdata, id_instr, id_pc, target;
  int          mem_lat, wait_cnt;
  int          n_vec = 0, n_err = 0;
  logic [31:0] q[$];

  if_fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_stall(pc_stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a == RPC) ? 32'h20080001 : {a[15:0], ~a[15:0]};
  endfunction

  // PC register: advances by 4, or loads the redirect target on flush
  always @(posedge clk or negedge rst)
    if (!rst) pc_in <= RPC;
    else if (!pc_stall) pc_in <= flush ? target : pc_in + 32'd4;

  // memory answering after mem_lat wait cycles
  always @(posedge clk or negedge rst)
    if (!rst) wait_cnt <= 0;
    else wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: the PC accepted on every issue is expected back at decode, in order
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst || flush) q.delete();
    else begin
      if (id_valid && id_ready) begin
        if (q.size() == 0) chk("sb_unexpected", id_pc, 32'hxxxxxxxx);
        else begin
          e = q.pop_front();
          chk("sb_pc", id_pc, e);
          chk("sb_instr", id_instr, f(e));
        end
      end
      if (!pc_stall) q.push_back(pc_in);
    end
  end

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        stall;
    logic        valid;
    logic [31:0] idpc;
  } vec_t;
  vec_t tbl[12];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    int waited;
    logic [31:0] hold;
    tbl[0]  = '{1'b0, 1'b0, RPC,           1'b0, 1'b0, 32'h0};
`ifdef FETCH_BYPASS_EN
    tbl[1]  = '{1'b0, 1'b1, RPC,           1'b0, 1'b1, RPC};
`else
    tbl[1]  = '{1'b0, 1'b1, RPC,           1'b0, 1'b0, 32'h0};
`endif
    tbl[2]  = '{1'b0, 1'b1, 32'h00400004, 1'b0, 1'b1, RPC};
    tbl[3]  = '{1'b0, 1'b1, 32'h00400008, 1'b0, 1'b1, RPC};
    tbl[4]  = '{1'b0, 1'b1, 32'h0040000C, 1'b1, 1'b1, RPC};
    tbl[5]  = '{1'b0, 1'b0, 32'h0040000C, 1'b1, 1'b1, RPC};
    tbl[6]  = '{1'b0, 1'b0, 32'h0040000C, 1'b1, 1'b1, RPC};
    tbl[7]  = '{1'b0, 1'b0, 32'h0040000C, 1'b1, 1'b1, RPC};
    tbl[8]  = '{1'b1, 1'b0, 32'h0040000C, 1'b1, 1'b1, RPC};
    tbl[9]  = '{1'b0, 1'b0, 32'h0040000C, 1'b0, 1'b1, 32'h00400004};
    tbl[10] = '{1'b0, 1'b1, 32'h00400010, 1'b1, 1'b1, 32'h00400004};
    tbl[11] = '{1'b0, 1'b0, 32'h00400010, 1'b1, 1'b1, 32'h00400004};
    rst = 1'b0; flush = 1'b0; id_ready = 1'b0; mem_lat = 0; target = 32'h00400100;
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_stall", pc_stall, 1'b0);
    cyc();
    rst = 1'b1;
    // zero-wait fill with decode stalled, then one pop restarts fetching
    for (int i = 0; i < 12; i++) begin
      id_ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("t%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_stall", i), pc_stall, tbl[i].stall);
      chk($sformatf("t%0d_valid", i), id_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("t%0d_idpc", i), id_pc, tbl[i].idpc);
        chk($sformatf("t%0d_instr", i), id_instr, f(tbl[i].idpc));
      end
      cyc();
    end
    id_ready = 1'b1;
    repeat (10) cyc();
    // steady push+pop with two entries held, wrapping the pointers
    id_ready = 1'b0;
    do_reset();
    repeat (3) cyc();
    id_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("pp_valid", id_valid, 1'b1);
      chk("pp_stall", pc_stall, 1'b0);
      chk("pp_req", imem_req, 1'b1);
      cyc();
    end
    // three wait cycles per request
    mem_lat = 3;
    waited = 0;
    hold = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) begin
        if (waited > 0) chk("lat_addr", imem_addr, hold);
        else hold = imem_addr;
        if (!imem_ack) begin
          chk("lat_stall", pc_stall, 1'b1);
          waited++;
        end else begin
          chk("lat_cycles", waited, 3);
          waited = 0;
        end
      end
      cyc();
    end
    // flush while the fetch of 0x00400008 waits for its ack
    do_reset();
    for (int k = 0; k < 40 && !(imem_req && imem_addr == 32'h00400008); k++) cyc();
    chk("fl_reach", imem_addr, 32'h00400008);
    id_ready = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_empty", id_valid, 1'b0);
    chk("fl_req", imem_req, 1'b1);
    chk("fl_addr", imem_addr, 32'h00400008);
    chk("fl_stall", pc_stall, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("fl_drain_valid", id_valid, 1'b0);
      if (imem_ack) break;
      cyc();
    end
    cyc();
    @(negedge clk);
    chk("fl_idle_req", imem_req, 1'b0);
    chk("fl_idle_valid", id_valid, 1'b0);
    chk("fl_idle_stall", pc_stall, 1'b0);
    cyc();
    @(negedge clk);
    chk("fl_redirect_req", imem_req, 1'b1);
    chk("fl_redirect_addr", imem_addr, 32'h00400100);
    id_ready = 1'b1;
    repeat (20) cyc();
`ifdef FETCH_BYPASS_EN
    mem_lat = 0;
    repeat (3) cyc();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("byp_valid", id_valid, 1'b1);
      chk("byp_ack", imem_ack, 1'b1);
      chk("byp_stall", pc_stall, 1'b0);
      cyc();
    end
`endif
    // reset while a request is outstanding drops imem_req at once
    mem_lat = 3;
    for (int k = 0; k < 10 && !imem_req; k++) cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_valid", id_valid, 1'b0);
    chk("arst_addr", imem_addr, RPC);
    cyc();
    rst = 1'b1;
    repeat (12) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch front end that consumes the current PC from the program counter register and issues instruction-memory reads with a req/ack handshake. Fetched words are buffered with their PC in a small FIFO and handed to decode through a valid/ready interface. The block drives the PC register's stall input, so the PC advances only when a fetch is actually issued. It sits between the PC register and the IF/ID pipeline register.

## Interface
- DEPTH, 4, FIFO entries; power of 2, at least 2
- RESET_PC, 32'h00400000, PC value held in the request address register at reset

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- pc_in  input  32  current PC from the PC register
- pc_stall  output  1  1 = PC register holds; 0 = PC register may load its next value
- flush  input  1  branch/jump redirect; discards buffered and in-flight fetches
- imem_req  output  1  read request to instruction memory (registered)
- imem_addr  output  32  read address (registered), stable while imem_req = 1
- imem_ack  input  1  memory has returned data this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack = 1
- id_valid  output  1  FIFO head holds a valid instruction
- id_instr  output  32  instruction at the FIFO head
- id_pc  output  32  PC of id_instr
- id_ready  input  1  decode accepts the head this cycle

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be kept.
  - DRAIN: request outstanding; its response will be discarded.
- `count` is the FIFO occupancy, 0..DEPTH. A pop happens when id_valid & id_ready.
- `issue` is combinational and true when flush = 0 and either:
  - state = IDLE and count < DEPTH, or
  - state = WAIT, imem_ack = 1, and count + 1 < DEPTH.
- On issue, pc_in is captured into imem_addr, imem_req is set to 1, and the next state is WAIT.
- pc_stall = ~(issue | flush). During flush, pc_stall = 0 so the PC register can load the redirect target.
- WAIT with imem_ack and no flush:
  - push {imem_addr, imem_rdata};
  - if there is no issue, clear imem_req and go to IDLE.
- WAIT with flush:
  - if imem_ack is also 1, the response is dropped; go to IDLE and clear imem_req;
  - otherwise go to DRAIN and keep imem_req high.
- DRAIN:
  - hold the request until imem_ack, discard the data, then go to IDLE;
  - a further flush while in DRAIN has no extra effect.
- IDLE with flush: issue nothing that cycle.
- Any flush empties the FIFO on the same edge (count and pointers go to 0) and ignores any pop that cycle.
- Push and pop in the same cycle leave count unchanged. The issue rule reserves a slot, so a push never finds the FIFO full.
- id_instr and id_pc are the head entry; their value is don't-care when id_valid = 0.

## Timing
- Reset values: state IDLE, count 0, pointers 0, imem_req 0, imem_addr RESET_PC, id_valid 0.
- pc_stall is 0 right after reset (IDLE, empty), so the first fetch issues on the first clock edge after rst deasserts.
- Fetch latency:
  - request visible the cycle after issue;
  - with zero-wait memory (imem_ack in that cycle), id_valid rises on the next cycle.
- Throughput: one fetch per cycle with zero-wait memory, until the FIFO reaches DEPTH−1 entries plus one in flight.
- Reset asserted mid-request: the outstanding request is abandoned immediately and imem_req falls asynchronously. The memory must tolerate a dropped request.

## Configuration
- FETCH_BYPASS_EN defined:
  - when count = 0, state = WAIT and imem_ack = 1, the block drives id_valid = 1, id_instr = imem_rdata and id_pc = imem_addr combinationally in that cycle;
  - if id_ready is also 1, nothing is pushed;
  - DRAIN responses are never bypassed, and flush suppresses the bypass.
- Not defined: id_* come only from the FIFO, with one cycle from imem_ack to id_valid.

## Test plan
- Reset release, pc_in = 0x00400000, memory acks in the same cycle with 0x20080001:
  - imem_req = 1 and imem_addr = 0x00400000 one cycle after release;
  - id_valid = 1, id_instr = 0x20080001 and id_pc = 0x00400000 one cycle later.
- id_ready = 0 held, DEPTH = 4, zero-wait memory:
  - exactly 4 words buffered;
  - pc_stall stays 1 and imem_req stays 0 thereafter;
  - raising id_ready for one cycle restarts the fetch.
- Memory with a 3-cycle ack delay:
  - imem_addr is stable and pc_stall = 1 for all wait cycles;
  - a single push happens on the ack.
- flush asserted during WAIT before the ack at 0x00400008:
  - FIFO is empty next cycle and the state enters DRAIN;
  - the late ack data never appears on id_*;
  - the next issue uses the redirected pc_in = 0x00400100.
- Simultaneous push and pop with count = 2: count stays 2 and FIFO order is preserved across pointer wrap-around after 10 transactions.
- FETCH_BYPASS_EN, empty FIFO, ack with 0x8C090004 and id_ready = 1: id_valid = 1 in the ack cycle and count stays 0.
